// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage feeding the IF/ID pipeline buffer
//
// Holds the PC, fetches 16-bit instructions over a req/ready handshake and
// presents pc/instruction pairs with active-low bubble and flush strobes.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   stall          hazard stall, freezes delivery
//   branch_taken   redirect request
//   branch_target  redirect PC
//   imem_req       memory request, held until imem_ready
//   imem_addr      fetch address (current PC)
//   imem_ready     read data valid for the outstanding request
//   imem_rdata     fetched instruction
//   pc_out         PC of the delivered instruction
//   inst_out       delivered instruction
//   nop_n          0 = no valid instruction this cycle
//   flush_n        active-low flush strobe
//   fetch_timeout  sticky memory-timeout flag
module if_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'd2,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_rdata,
    output logic [15:0] pc_out,
    output logic [15:0] inst_out,
    output logic        nop_n,
    output logic        flush_n,
    output logic        fetch_timeout
);

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        HOLD  = 3'd4
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      state;
    state_t      next_state;
    logic [15:0] pc;
    logic [15:0] skid_pc;
    logic [15:0] skid_inst;
    logic        skid_valid;
    logic [7:0]  wait_cnt;

    logic        accept;
    logic        deliver_mem;
    logic        deliver_skid;
    logic        capture_skid;
    logic        waiting;

    assign imem_addr = pc;

    // A branch kills whatever the current cycle would have delivered or captured.
    always_comb begin
        accept       = (state == WAIT) && imem_ready;
        deliver_mem  = accept && !stall && !branch_taken;
        capture_skid = accept && stall && !branch_taken;
        deliver_skid = (state == HOLD) && !stall && skid_valid && !branch_taken;
        waiting      = (state == WAIT) || (state == DRAIN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= BOOT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (branch_taken) begin
            // An outstanding request with no response yet must be drained so
            // its late data is not mistaken for the redirected fetch.
            if ((state == WAIT) && !imem_ready) begin
                next_state = DRAIN;
            end else begin
                next_state = REQ;
            end
        end else begin
            case (state)
                BOOT:    next_state = REQ;
                REQ:     next_state = (stall || skid_valid) ? HOLD : WAIT;
                WAIT:    next_state = imem_ready ? REQ : WAIT;
                DRAIN:   next_state = imem_ready ? REQ : DRAIN;
                HOLD:    next_state = stall ? HOLD : REQ;
                default: next_state = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc            <= RESET_PC;
            imem_req      <= 1'b0;
            pc_out        <= 16'h0000;
            inst_out      <= 16'h0000;
            nop_n         <= 1'b0;
            flush_n       <= 1'b1;
            fetch_timeout <= 1'b0;
            skid_pc       <= 16'h0000;
            skid_inst     <= 16'h0000;
            skid_valid    <= 1'b0;
            wait_cnt      <= 8'h00;
        end else begin
            // The request is high exactly while the FSM sits in WAIT.
            imem_req <= (next_state == WAIT);
            flush_n  <= !branch_taken;

            if (branch_taken) begin
                pc         <= branch_target;
                skid_valid <= 1'b0;
                nop_n      <= 1'b0;
            end else begin
                if (deliver_mem) begin
                    pc_out   <= pc;
                    inst_out <= imem_rdata;
                    nop_n    <= 1'b1;
                end else if (deliver_skid) begin
                    pc_out   <= skid_pc;
                    inst_out <= skid_inst;
                    nop_n    <= 1'b1;
                end else if (!stall) begin
                    nop_n <= 1'b0;
                end

                // The PC advances on every accepted response, stalled or not.
                if (accept) begin
                    pc <= pc + PC_STEP;
                end

                if (capture_skid) begin
                    skid_pc    <= pc;
                    skid_inst  <= imem_rdata;
                    skid_valid <= 1'b1;
                end else if (deliver_skid) begin
                    skid_valid <= 1'b0;
                end
            end

            if (waiting && !imem_ready && (wait_cnt == WAIT_LAST)) begin
                fetch_timeout <= 1'b1;
            end

            if ((next_state != state) && ((next_state == WAIT) || (next_state == DRAIN))) begin
                wait_cnt <= 8'h00;
            end else if (waiting && !imem_ready && (wait_cnt != 8'hFF)) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - scoreboard bench for if_fetch_unit
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst2;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        imem_ready;
    logic [15:0] imem_rdata;

    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] pc_out;
    logic [15:0] inst_out;
    logic        nop_n;
    logic        flush_n;
    logic        fetch_timeout;

    logic        d2_imem_req;
    logic [15:0] d2_imem_addr;
    logic [15:0] d2_pc_out;
    logic [15:0] d2_inst_out;
    logic        d2_nop_n;
    logic        d2_flush_n;
    logic        d2_fetch_timeout;

    if_fetch_unit #(.RESET_PC(16'h0000), .PC_STEP(16'd2), .MAX_WAIT(15)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .pc_out(pc_out),
        .inst_out(inst_out), .nop_n(nop_n), .flush_n(flush_n),
        .fetch_timeout(fetch_timeout)
    );

    if_fetch_unit #(.RESET_PC(16'hFFFE), .PC_STEP(16'd2), .MAX_WAIT(15)) dut2 (
        .clk(clk), .rst(rst2), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_req(d2_imem_req), .imem_addr(d2_imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .pc_out(d2_pc_out),
        .inst_out(d2_inst_out), .nop_n(d2_nop_n), .flush_n(d2_flush_n),
        .fetch_timeout(d2_fetch_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_del[$];
    logic [31:0] exp2_del[$];
    logic [15:0] exp_addr[$];
    logic [15:0] exp2_addr[$];
    int          lat_q[$];
    logic [15:0] dat_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_req(input logic [15:0] a, input logic need_ready, input string name);
        int n = 0;
        while (!(imem_req && (imem_addr == a) && (!need_ready || imem_ready)) && (n < 300)) begin
            step();
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL %s no request at %h within budget", name, a);
        end
    endtask

    // Delivery scoreboards: every nop_n=1 cycle must match the next expected pair.
    always @(negedge clk) begin
        if (nop_n === 1'b1) begin
            if (exp_del.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL delivery unexpected actual=%h required=none", {pc_out, inst_out});
            end else begin
                check("delivery", {pc_out, inst_out}, exp_del.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (d2_nop_n === 1'b1) begin
            if (exp2_del.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL delivery2 unexpected actual=%h required=none", {d2_pc_out, d2_inst_out});
            end else begin
                check("delivery2", {d2_pc_out, d2_inst_out}, exp2_del.pop_front());
            end
        end
    end

    // Request scoreboards: each rising imem_req must carry the next expected address.
    logic req_prev  = 1'b0;
    logic req2_prev = 1'b0;

    always @(negedge clk) begin
        if (imem_req && !req_prev) begin
            if (exp_addr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL req_addr unexpected actual=%h required=none", imem_addr);
            end else begin
                check("req_addr", {16'h0, imem_addr}, {16'h0, exp_addr.pop_front()});
            end
        end
        req_prev <= imem_req;
    end

    always @(negedge clk) begin
        if (d2_imem_req && !req2_prev) begin
            if (exp2_addr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL req_addr2 unexpected actual=%h required=none", d2_imem_addr);
            end else begin
                check("req_addr2", {16'h0, d2_imem_addr}, {16'h0, exp2_addr.pop_front()});
            end
        end
        req2_prev <= d2_imem_req;
    end

    // Memory model: one outstanding request, answered after a programmed
    // number of extra cycles, even if the request is withdrawn meanwhile.
    initial begin
        bit          busy;
        int          cnt;
        int          lat;
        logic [15:0] dat;
        busy       = 1'b0;
        cnt        = 0;
        lat        = 0;
        dat        = 16'h0;
        imem_ready = 1'b0;
        imem_rdata = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            imem_ready = 1'b0;
            if (!rst) begin
                busy = 1'b0;
            end else begin
                if (!busy && imem_req && (lat_q.size() > 0)) begin
                    busy = 1'b1;
                    cnt  = 0;
                    lat  = lat_q.pop_front();
                    dat  = dat_q.pop_front();
                end
                if (busy) begin
                    if (cnt == lat) begin
                        imem_ready = 1'b1;
                        imem_rdata = dat;
                        busy       = 1'b0;
                    end else begin
                        cnt++;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst           = 1'b0;
        rst2          = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 16'h0000;

        // latency (extra cycles), data per accepted/killed request
        lat_q = '{0, 0, 2, 0, 3, 0, 1, 0, 20};
        dat_q = '{16'h1111, 16'h2222, 16'hABCD, 16'h3333, 16'hDEAD,
                  16'h4444, 16'h5555, 16'h6666, 16'h7777};
        exp_addr = '{16'h0000, 16'h0002, 16'h0004, 16'h0006, 16'h0008,
                     16'h0100, 16'h0102, 16'h0200, 16'h0202, 16'h0204};
        exp_del  = '{32'h0000_1111, 32'h0002_2222, 32'h0004_ABCD, 32'h0006_3333,
                     32'h0100_4444, 32'h0200_6666, 32'h0202_7777};
        exp2_addr = '{16'hFFFE, 16'h0000};
        exp2_del  = '{32'hFFFE_1111, 32'h0000_2222};

        step();
        step();
        check("rst_imem_req", imem_req, 0);
        check("rst_imem_addr", imem_addr, 16'h0000);
        check("rst_pc_out", pc_out, 16'h0000);
        check("rst_inst_out", inst_out, 16'h0000);
        check("rst_nop_n", nop_n, 0);
        check("rst_flush_n", flush_n, 1);
        check("rst_timeout", fetch_timeout, 0);
        check("rst_addr2", d2_imem_addr, 16'hFFFE);

        rst  = 1'b1;
        rst2 = 1'b1;

        // Basic streaming, plus the wrap-around instance.
        n = 0;
        while ((exp2_del.size() != 0) && (n < 100)) begin
            step();
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL wrap_delivery not seen within budget");
        end
        rst2 = 1'b0;

        // Stall during WAIT: response parks in the skid, outputs frozen.
        wait_req(16'h0004, 1'b0, "stall_req");
        stall = 1'b1;
        repeat (6) step();
        check("stall_req_low", imem_req, 0);
        check("stall_nop_hold", nop_n, 0);
        check("stall_pc_hold", pc_out, 16'h0002);
        check("stall_inst_hold", inst_out, 16'h2222);
        stall = 1'b0;

        // Branch while waiting: drain the killed response.
        wait_req(16'h0008, 1'b0, "branch_req");
        branch_taken  = 1'b1;
        branch_target = 16'h0100;
        step();
        branch_taken = 1'b0;
        check("branch_flush_low", flush_n, 0);
        check("branch_nop", nop_n, 0);
        check("branch_req_low", imem_req, 0);
        step();
        check("branch_flush_high", flush_n, 1);
        repeat (3) step();
        check("drain_inst_hold", inst_out, 16'h3333);
        check("drain_next_addr", imem_addr, 16'h0100);

        // Branch on the same edge as the response: data dropped.
        wait_req(16'h0102, 1'b1, "same_edge_req");
        branch_taken  = 1'b1;
        branch_target = 16'h0200;
        step();
        branch_taken = 1'b0;
        check("same_edge_nop", nop_n, 0);
        check("same_edge_flush", flush_n, 0);
        check("same_edge_pc_hold", pc_out, 16'h0100);
        check("same_edge_inst_hold", inst_out, 16'h4444);

        // Slow memory: timeout after 15 WAIT cycles, sticky until reset.
        wait_req(16'h0202, 1'b0, "timeout_req");
        repeat (14) step();
        check("timeout_before", fetch_timeout, 0);
        step();
        check("timeout_set", fetch_timeout, 1);
        n = 0;
        while ((exp_addr.size() != 0) && (n < 100)) begin
            step();
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL post_timeout_req not seen within budget");
        end
        step();
        check("timeout_sticky", fetch_timeout, 1);

        rst = 1'b0;
        #1;
        check("rst2_timeout", fetch_timeout, 0);
        check("rst2_nop_n", nop_n, 0);
        check("rst2_pc_out", pc_out, 16'h0000);
        check("rst2_imem_req", imem_req, 0);
        check("rst2_imem_addr", imem_addr, 16'h0000);
        step();
        step();

        check("pending_deliveries", exp_del.size(), 0);
        check("pending_addrs", exp_addr.size(), 0);
        check("pending_deliveries2", exp2_del.size(), 0);
        check("pending_addrs2", exp2_addr.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage directly upstream of the IF/ID pipeline buffer. Holds the 16-bit PC and issues requests to instruction memory over a req/ready handshake. Presents pc/instruction pairs plus active-low bubble and flush strobes that the IF/ID buffer consumes. Also handles hazard stalls, branch redirects and memory-latency timeout reporting.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
PC_STEP, 2, PC increment per delivered instruction (byte-addressed 16-bit instructions)
MAX_WAIT, 15, WAIT-state cycles without imem_ready before fetch_timeout sets (1..255)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
stall  in  1  hazard stall, active-high; freezes delivery
branch_taken  in  1  redirect request, sampled at rising edge
branch_target  in  16  redirect PC
imem_req  out  1  memory request, held high until ready
imem_addr  out  16  fetch address (= pc), stable while imem_req high
imem_ready  in  1  rdata valid for the outstanding request
imem_rdata  in  16  fetched instruction
pc_out  out  16  PC of delivered instruction (to pc_buff_in)
inst_out  out  16  delivered instruction (to inst_buff_in)
nop_n  out  1  active-low bubble (to nop_in): 0 = no valid instruction this cycle
flush_n  out  1  active-low flush pulse (to flush)
fetch_timeout  out  1  sticky memory-timeout flag

Behaviour:
- Clock is clk; reset is rst: asynchronous, active-low.
- On reset:
  - pc=RESET_PC; state=BOOT.
  - imem_req=0; pc_out=0; inst_out=0; nop_n=0; flush_n=1; fetch_timeout=0.
  - Skid register cleared; wait counter cleared.
- States: BOOT, REQ, WAIT, DRAIN, HOLD.
- Transitions:
  - BOOT: one cycle, no request, then REQ.
  - REQ: if stall=1 or skid_valid=1, go to HOLD with no request. Otherwise assert imem_req with imem_addr=pc and go to WAIT.
  - WAIT: imem_req stays high and the wait counter increments each cycle. On imem_ready=1 the response is accepted; imem_req drops next cycle; state returns to REQ.
  - Accept with stall=0: pc_out<=pc, inst_out<=imem_rdata, nop_n<=1 for that cycle, pc<=pc+PC_STEP.
  - Accept with stall=1: capture into skid (skid_pc, skid_inst, skid_valid=1); pc still advances.
  - HOLD: no request. When stall=0 and skid_valid=1, deliver the skid entry (nop_n=1 one cycle), clear skid, go to REQ. When stall=0 and skid empty, go to REQ.
  - DRAIN: imem_req low. Wait for imem_ready of the killed request, discard its data, then go to REQ.
- Output rules:
  - nop_n=0 in every cycle where no instruction is delivered and stall=0.
  - While stall=1, pc_out, inst_out and nop_n hold their previous values.
- Branch redirect (branch_taken=1 at an edge) has top priority, overriding stall, skid and any pending accept:
  - pc<=branch_target; skid_valid<=0; nop_n<=0; flush_n<=0 for exactly one cycle, then 1.
  - From WAIT with imem_ready=0: go to DRAIN.
  - From WAIT with imem_ready=1 the same cycle: discard that data, go to REQ.
  - From any other state: go to REQ.
  - Back-to-back branches: the last target wins; flush_n stays low while branch_taken persists.
- Arithmetic: PC addition is modulo 2^16 (16'hFFFE+2 -> 16'h0000). branch_target is used unmodified.
- Timeout:
  - The wait counter resets on entry to WAIT/DRAIN.
  - When it reaches MAX_WAIT with no ready, fetch_timeout<=1 and stays 1 until reset.
  - The FSM keeps waiting; no request is abandoned.
- Reset mid-operation: all state returns to reset values immediately. A late imem_ready after reset is ignored because BOOT does not accept.
- Latency: the instruction appears on inst_out the cycle after the imem_ready edge. Best-case throughput is one instruction per 2 cycles when ready returns in 1 cycle.

Test Plan:
- Reset, then ready 1 cycle after each req, rdata=16'h1111,16'h2222 -> imem_addr 0000 then 0002; pc_out/inst_out = 0000/1111 then 0002/2222; nop_n high one cycle each, low otherwise.
- stall=1 asserted while WAIT at pc=0004, ready with 16'hABCD -> outputs frozen, no new req; after stall=0, next cycle pc_out=0004, inst_out=ABCD, nop_n=1, then req at 0006.
- branch_taken=1, target=16'h0100 while WAIT at 0008 with ready delayed 3 cycles -> flush_n low exactly one cycle, DRAIN discards data (inst_out unchanged), next imem_addr=0100.
- Branch on the same edge as imem_ready -> data dropped, nop_n=0, next req at target.
- RESET_PC=16'hFFFE -> first delivery pc_out=FFFE, next imem_addr=0000.
- imem_ready withheld 20 cycles with MAX_WAIT=15 -> fetch_timeout=1 after 15 WAIT cycles and stays 1 after the late ready; cleared only by rst=0.
